clock_divider_prog: RTL and testbench
=====================================

# clock_divider_prog

Runtime-programmable clock divider: generates a divided clock level plus single-cycle rise/fall tick strobes from `i_clock`, with an arbitrary integer divisor. The divisor is loaded through a valid/ready handshake and applied only at a period boundary, so the output is glitch-free. A run/stop enable provides a clean restart. It sits beside the fixed power-of-two divider and feeds slow-clock domains and periodic enables (debug UART baud, stepping logic) in the MIPS top level.

## Interface
- `NB_DIV`, 16: width of divisor, counter and divisor ports.
- `DEFAULT_DIV`, 2: divisor active after reset; must be ≥2.
- `i_clock` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: reset, synchronous, active-low (0 = reset).
- `i_enable` in 1: 1 = run, 0 = stop (output parked low).
- `i_div_valid` in 1: new divisor offered.
- `i_div` in NB_DIV: requested divisor D (input clocks per output period).
- `o_div_ready` out 1: divisor request can be accepted.
- `o_div_active` out NB_DIV: divisor currently in effect.
- `o_clock_div` out 1: divided clock level, registered.
- `o_rise_tick` out 1: one-cycle strobe, first high cycle of each period.
- `o_fall_tick` out 1: one-cycle strobe, first low cycle of each period.

## Operation
- Phase counter `cnt` (NB_DIV bits) runs 0..D_act−1. Let H = D_act − (D_act>>1) (high cycles) and L = D_act>>1 (low cycles). Odd D gives the extra cycle to the high phase.
- Each enabled edge:
  - cnt_next = (cnt == D_act−1) ? 0 : cnt+1.
  - o_clock_div <= (cnt_next < H).
  - o_rise_tick <= (cnt_next == 0).
  - o_fall_tick <= (cnt_next == H).
- Handshake: a transfer occurs on an edge with i_div_valid=1 and o_div_ready=1. i_div is captured into a pending register and o_div_ready drops to 0. While o_div_ready=0, valid is ignored: no stall, no overwrite.
- Clamp: a captured value <2 is stored as 2.
- Apply: on an enabled edge with cnt == D_act−1 and a pending value present, D_act <= pending and cnt <= 0. The new period starts immediately with the new H. o_div_ready returns to 1 on the following edge.
  - A transfer on that same wrap edge is not applied there; it waits for the next wrap.
- Stop (i_enable=0 at an edge):
  - cnt <= D_act−1 and o_clock_div <= 0.
  - o_rise_tick <= 0 and o_fall_tick <= o_clock_div, so a fall tick is issued only if the output was high.
  - Any pending divisor is applied immediately and o_div_ready returns to 1 on the next edge.
  - Handshake remains live while stopped.
- Restart: the first enabled edge after stop or reset gives cnt=0, o_clock_div=1, o_rise_tick=1.

## Timing
- Reset (i_reset=0 at an edge):
  - o_clock_div=0, o_rise_tick=0, o_fall_tick=0, o_div_ready=1.
  - o_div_active=DEFAULT_DIV, cnt=DEFAULT_DIV−1.
  - Pending divisor discarded. Reset overrides enable and handshake, including mid-period.
- Latency: o_clock_div rises on the first edge with i_reset=1 and i_enable=1.
- Period is exactly D_act input cycles: H cycles high, L cycles low. The rise tick coincides with the first high cycle and the fall tick with the first low cycle.
- D=2: output toggles every cycle; ticks alternate every cycle.
- Divisor change takes effect at the first wrap after capture, i.e. at most D_act cycles later. No period is truncated or stretched. o_div_ready is low for (cycles to wrap)+1 edges.
- o_div_active updates on the same edge as the apply.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then enable=1 with DEFAULT_DIV=2 -> o_clock_div 1,0,1,0…; rise ticks on cycles 1,3,5; fall ticks on cycles 2,4,6.
- Load D=5 while stopped, then enable -> repeating pattern 1,1,1,0,0; rise tick every 5 cycles; o_div_active=5.
- Running at D=4, load D=6 at phase cnt=1 -> two more cycles of D=4, then clean 1,1,1,0,0,0 periods. o_div_ready is low 3 edges, then high. A second valid while ready=0 is ignored.
- Load i_div=0 -> o_div_active=2 after the next wrap, output toggles every cycle.
- D=6, drop i_enable at cnt=1 (output high) -> next edge o_clock_div=0 with fall tick. Re-enable -> rise on the first enabled edge and a full 6-cycle period.
- D=8, pending D=3, assert i_reset mid-period -> all outputs at reset values, o_div_active=DEFAULT_DIV, pending lost, and after release the period is DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor changes.
// Emits a registered divided-clock level plus one-cycle rise/fall tick strobes.
module clock_divider_prog #(
  parameter int NB_DIV      = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_div_valid,
  input  logic [NB_DIV-1:0] i_div,
  output logic              o_div_ready,
  output logic [NB_DIV-1:0] o_div_active,
  output logic              o_clock_div,
  output logic              o_rise_tick,
  output logic              o_fall_tick
);

  localparam logic [NB_DIV-1:0] C_DEF = NB_DIV'(DEFAULT_DIV);
  localparam logic [NB_DIV-1:0] C_ONE = NB_DIV'(1);
  localparam logic [NB_DIV-1:0] C_TWO = NB_DIV'(2);

  logic [NB_DIV-1:0] r_cnt;
  logic [NB_DIV-1:0] r_div_active;
  logic [NB_DIV-1:0] r_pend_div;
  logic              r_pend_valid;
  logic              r_div_ready;
  logic              r_clock_div;
  logic              r_rise_tick;
  logic              r_fall_tick;

  logic              w_xfer;
  logic              w_wrap;
  logic              w_apply;
  logic [NB_DIV-1:0] w_div_next;
  logic [NB_DIV-1:0] w_cnt_next;
  logic [NB_DIV-1:0] w_high;
  logic [NB_DIV-1:0] w_div_clamped;

  // Handshake: a divisor transfers on any edge where i_div_valid and
  // o_div_ready are both high; while o_div_ready is low, valid is ignored.
  always_comb begin
    w_xfer        = i_div_valid & r_div_ready;
    w_wrap        = (r_cnt >= (r_div_active - C_ONE));
    w_apply       = r_pend_valid & (~i_enable | w_wrap);
    w_div_next    = w_apply ? r_pend_div : r_div_active;
    w_cnt_next    = w_wrap ? '0 : (r_cnt + C_ONE);
    w_high        = w_div_next - (w_div_next >> 1);
    w_div_clamped = (i_div < C_TWO) ? C_TWO : i_div;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cnt        <= C_DEF - C_ONE;
      r_div_active <= C_DEF;
      r_pend_div   <= C_DEF;
      r_pend_valid <= 1'b0;
      r_div_ready  <= 1'b1;
      r_clock_div  <= 1'b0;
      r_rise_tick  <= 1'b0;
      r_fall_tick  <= 1'b0;
    end else begin
      if (i_enable) begin
        r_cnt       <= w_cnt_next;
        r_clock_div <= (w_cnt_next < w_high);
        r_rise_tick <= (w_cnt_next == '0);
        r_fall_tick <= (w_cnt_next == w_high);
      end else begin
        // Park at the last phase so the first enabled edge starts a fresh period.
        r_cnt       <= w_div_next - C_ONE;
        r_clock_div <= 1'b0;
        r_rise_tick <= 1'b0;
        r_fall_tick <= r_clock_div;
      end

      r_div_active <= w_div_next;

      if (w_apply) begin
        r_pend_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_pend_div   <= w_div_clamped;
        r_pend_valid <= 1'b1;
      end

      // Ready reopens one edge after the pending value has been consumed.
      if (w_xfer) begin
        r_div_ready <= 1'b0;
      end else if (!r_div_ready && !r_pend_valid) begin
        r_div_ready <= 1'b1;
      end
    end
  end

  assign o_div_ready  = r_div_ready;
  assign o_div_active = r_div_active;
  assign o_clock_div  = r_clock_div;
  assign o_rise_tick  = r_rise_tick;
  assign o_fall_tick  = r_fall_tick;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: reset/startup vector table, directed corner
// sequences, then randomized traffic checked against a period-level model.
module tb_clock_divider_prog;

  localparam int NB_DIV = 16;
  localparam int DEF    = 2;

  logic              clk;
  logic              i_reset;
  logic              i_enable;
  logic              i_div_valid;
  logic [NB_DIV-1:0] i_div;
  logic              o_div_ready;
  logic [NB_DIV-1:0] o_div_active;
  logic              o_clock_div;
  logic              o_rise_tick;
  logic              o_fall_tick;

  int n_cmp = 0;
  int n_bad = 0;

  clock_divider_prog #(.NB_DIV(NB_DIV), .DEFAULT_DIV(DEF)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_div_valid (i_div_valid),
    .i_div       (i_div),
    .o_div_ready (o_div_ready),
    .o_div_active(o_div_active),
    .o_clock_div (o_clock_div),
    .o_rise_tick (o_rise_tick),
    .o_fall_tick (o_fall_tick)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: position within the output period, active divisor,
  // and a queue holding at most one pending divisor.
  int m_pos;
  int m_div;
  int m_pend[$];
  bit m_ready;
  bit m_applied;
  bit m_clk;
  bit m_rise;
  bit m_fall;

  function automatic void model_update(bit rst, bit en, bit valid, int div);
    bit xfer;
    bit wrap;
    bit apply;
    int h;
    if (!rst) begin
      m_div = DEF; m_pos = DEF - 1;
      m_clk = 0; m_rise = 0; m_fall = 0;
      m_ready = 1; m_applied = 0;
      m_pend.delete();
      return;
    end
    xfer  = valid && m_ready;
    wrap  = (m_pos == m_div - 1);
    apply = (m_pend.size() > 0) && (!en || wrap);
    if (en) begin
      if (apply) m_div = m_pend.pop_front();
      m_pos  = wrap ? 0 : m_pos + 1;
      h      = m_div - m_div / 2;
      m_clk  = (m_pos < h);
      m_rise = (m_pos == 0);
      m_fall = (m_pos == h);
    end else begin
      m_fall = m_clk;
      m_clk  = 0;
      m_rise = 0;
      if (apply) m_div = m_pend.pop_front();
      m_pos = m_div - 1;
    end
    if (xfer) m_ready = 0;
    else if (m_applied) m_ready = 1;
    m_applied = apply;
    if (xfer) m_pend.push_back((div < 2) ? 2 : div);
  endfunction

  // Scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%0d exp=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Driver: apply inputs for one edge, then compare all outputs to the model.
  task automatic step(input logic rst, input logic en, input logic valid,
                      input logic [NB_DIV-1:0] div);
    i_reset = rst; i_enable = en; i_div_valid = valid; i_div = div;
    @(posedge clk);
    #1;
    model_update(rst, en, valid, int'(div));
    chk("model_clock_div", 32'(o_clock_div), 32'(m_clk));
    chk("model_rise_tick", 32'(o_rise_tick), 32'(m_rise));
    chk("model_fall_tick", 32'(o_fall_tick), 32'(m_fall));
    chk("model_div_ready", 32'(o_div_ready), 32'(m_ready));
    chk("model_div_active", 32'(o_div_active), 32'(m_div));
  endtask

  task automatic exp5(input string nm, input logic c, input logic r, input logic f,
                      input logic rd, input logic [NB_DIV-1:0] a);
    chk({nm, "_clk"}, 32'(o_clock_div), 32'(c));
    chk({nm, "_rise"}, 32'(o_rise_tick), 32'(r));
    chk({nm, "_fall"}, 32'(o_fall_tick), 32'(f));
    chk({nm, "_ready"}, 32'(o_div_ready), 32'(rd));
    chk({nm, "_active"}, 32'(o_div_active), 32'(a));
  endtask

  typedef struct {
    logic rst; logic en; logic valid; logic [NB_DIV-1:0] div;
    logic clk; logic rise; logic fall; logic ready; logic [NB_DIV-1:0] active;
  } vec_t;

  vec_t vecs[12];

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_div_valid = 1'b0; i_div = '0;

    // Reset and DEFAULT_DIV=2 startup, including stop/restart at the edges.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].en, vecs[v].valid, vecs[v].div);
      exp5($sformatf("vec%0d", v), vecs[v].clk, vecs[v].rise, vecs[v].fall,
           vecs[v].ready, vecs[v].active);
    end

    // Load D=5 while stopped, then run: 1,1,1,0,0 pattern.
    step(1, 0, 1, 16'd5);
    exp5("d5_xfer", 0, 0, 0, 0, 16'd2);
    step(1, 0, 0, 16'd0);
    exp5("d5_apply", 0, 0, 0, 0, 16'd5);
    step(1, 0, 0, 16'd0);
    chk("d5_ready_back", 32'(o_div_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 16'd0);
      chk("d5_clk", 32'(o_clock_div), 32'((i % 5) < 3));
      chk("d5_rise", 32'(o_rise_tick), 32'((i % 5) == 0));
      chk("d5_fall", 32'(o_fall_tick), 32'((i % 5) == 3));
    end
    chk("d5_active", 32'(o_div_active), 32'd5);

    // Running at D=4, load D=6 at phase 1; second valid while busy is ignored.
    step(1, 0, 1, 16'd4);
    step(1, 0, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    step(1, 1, 0, 16'd0);
    exp5("d46_p0", 1, 1, 0, 1, 16'd4);
    step(1, 1, 0, 16'd0);
    exp5("d46_p1", 1, 0, 0, 1, 16'd4);
    step(1, 1, 1, 16'd6);
    exp5("d46_p2", 0, 0, 1, 0, 16'd4);
    step(1, 1, 1, 16'd9);
    exp5("d46_p3", 0, 0, 0, 0, 16'd4);
    step(1, 1, 0, 16'd0);
    exp5("d46_apply", 1, 1, 0, 0, 16'd6);
    step(1, 1, 0, 16'd0);
    exp5("d46_ready", 1, 0, 0, 1, 16'd6);
    for (int i = 2; i < 12; i++) begin
      step(1, 1, 0, 16'd0);
      chk("d6_clk", 32'(o_clock_div), 32'((i % 6) < 3));
      chk("d6_rise", 32'(o_rise_tick), 32'((i % 6) == 0));
    end
    chk("d6_active", 32'(o_div_active), 32'd6);

    // i_div=0 offered on a wrap edge: clamps to 2, applied at the following wrap.
    step(1, 1, 1, 16'd0);
    exp5("clamp_xfer", 1, 1, 0, 0, 16'd6);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 16'd0);
    exp5("clamp_apply", 1, 1, 0, 0, 16'd2);
    for (int j = 0; j < 4; j++) begin
      step(1, 1, 0, 16'd0);
      chk("clamp_toggle", 32'(o_clock_div), 32'(j % 2));
    end

    // D=6, stop while high: fall tick, then clean restart and full period.
    step(1, 0, 1, 16'd6);
    exp5("stop_hi", 0, 0, 1, 0, 16'd2);
    step(1, 0, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    step(1, 1, 0, 16'd0);
    step(1, 1, 0, 16'd0);
    exp5("d6_cnt1", 1, 0, 0, 1, 16'd6);
    step(1, 0, 0, 16'd0);
    exp5("d6_stop", 0, 0, 1, 1, 16'd6);
    step(1, 1, 0, 16'd0);
    exp5("d6_restart", 1, 1, 0, 1, 16'd6);
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, 16'd0);
      chk("restart_clk", 32'(o_clock_div), 32'((i % 6) < 3));
      chk("restart_rise", 32'(o_rise_tick), 32'((i % 6) == 0));
      chk("restart_fall", 32'(o_fall_tick), 32'((i % 6) == 3));
    end

    // D=8 with D=3 pending, reset mid-period: pending lost, period back to 2.
    step(1, 0, 1, 16'd8);
    step(1, 0, 0, 16'd0);
    step(1, 0, 0, 16'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 16'd0);
    step(1, 1, 1, 16'd3);
    chk("d8_pend_ready", 32'(o_div_ready), 32'd0);
    step(1, 1, 0, 16'd0);
    step(0, 1, 1, 16'd7);
    exp5("mid_reset", 0, 0, 0, 1, 16'd2);
    for (int j = 0; j < 6; j++) begin
      step(1, 1, 0, 16'd0);
      exp5("post_reset", (j % 2) == 0, (j % 2) == 0, (j % 2) == 1, 1, 16'd2);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic r_rst;
      logic r_en;
      logic r_val;
      logic [NB_DIV-1:0] r_div;
      r_rst = ($urandom_range(0, 199) != 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_val = ($urandom_range(0, 4) == 0);
      r_div = ($urandom_range(0, 7) == 0) ? NB_DIV'($urandom_range(0, 40))
                                          : NB_DIV'($urandom_range(0, 9));
      step(r_rst, r_en, r_val, r_div);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
